debug_access_unit: RTL and testbench
====================================

# debug_access_unit

Executes single debug transactions against the halted core on behalf of the debug controller. It sits directly downstream of the debug controller. Each rising-level `tx_flag` with a valid `mode` becomes one register-file or data-memory access. Read data returns on `data_internal`, and a one-cycle `doneSending` pulse closes the handshake.

## Interface
- `TIMEOUT`, default 255: maximum cycles `mem_req` is held waiting for `mem_ack`. Legal range 1..65535.
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-high.
- `tx_flag` in 1: transaction request from the debug controller, level.
- `mode` in 3: 001 GPR read, 010 GPR write, 101 memory read, 110 memory write. All other codes are no-op.
- `address_bridged` in 32: target address. GPR index is `[4:0]`; memory uses a byte address.
- `data_bridged` in 32: write data.
- `data_internal` out 32: last read result, fed back to the controller's readback register.
- `doneSending` out 1: one-cycle completion pulse.
- `busy` out 1: high when the state is not IDLE.
- `error` out 1: last transaction failed (unaligned or timeout).
- `rf_addr` out 5, `rf_we` out 1, `rf_wdata` out 32: register-file debug port.
- `rf_rdata` in 32: register-file read data, synchronous, valid one cycle after `rf_addr`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_be` out 4: data-memory debug port.
- `mem_rdata` in 32, `mem_ack` in 1: memory response, single-cycle ack.

## Operation
- Reset values: `data_internal`=0, `doneSending`=0, `busy`=0, `error`=0, `rf_we`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `rf_addr`=0, `mem_addr`=0, all write data 0. State is IDLE.
- Transaction accept (IDLE, `tx_flag`=1, valid mode):
  - latch mode, address and data;
  - clear `error` and the timeout counter.
- No-op modes with `tx_flag`=1: stay in IDLE, no pulse.
- IDLE transitions:
  - 001 → RF_RD.
  - 010 → RF_WR.
  - 101/110 → MEM_REQ if latched `address[1:0]`==0.
  - 101/110 with `address[1:0]`≠0 → ERR.
- RF_RD: drive `rf_addr`=addr[4:0], go to RF_CAP. RF_CAP captures `rf_rdata` into `data_internal`, then DONE.
- RF_WR: drive `rf_we`=1 for one cycle with `rf_wdata`=latched data, then DONE. Index 0 suppresses `rf_we`, but the block still goes to DONE with no error.
- MEM_REQ outputs:
  - `mem_req`=1;
  - `mem_addr`={addr[31:2],2'b00};
  - `mem_be`=4'b1111;
  - `mem_we`=1 for 110;
  - `mem_wdata`=latched data.
- MEM_REQ completion:
  - on a cycle with `mem_ack`=1: 101 captures `mem_rdata` into `data_internal`; go to DONE and drop `mem_req` next cycle;
  - otherwise the counter increments; when it reaches `TIMEOUT`, go to ERR.
- ERR: set `error`=1, set `data_internal`=0, go to DONE.
- DONE: `doneSending`=1 for exactly one cycle, then go to WAIT_LOW.
- WAIT_LOW: stay until `tx_flag`=0, then IDLE. This prevents retriggering on the still-high level.
- Writes never modify `data_internal`. `error` stays set until the next accept.
- `tx_flag` falling mid-transaction does not abort the transaction. It completes, still pulses `doneSending`, then WAIT_LOW exits to IDLE immediately.
- Reset mid-transaction drops `mem_req` and `rf_we` asynchronously. No partial write may be retried after reset.

## Timing
- Outputs are registered or decoded from state only. No combinational path from `tx_flag` to any output.
- Edge numbering: E0 is the accept edge.
- GPR read: RF_RD in cycle 1, capture at E2, `doneSending` high in cycle 3, `data_internal` valid from cycle 3.
- GPR write: `rf_we` high in cycle 1, `doneSending` high in cycle 2.
- Memory:
  - `mem_req` goes high in cycle 1.
  - If `mem_ack` arrives in cycle k, `doneSending` is high in cycle k+1.
  - Minimum latency is 2 cycles, with ack in cycle 1.
- Timeout: `doneSending` is high `TIMEOUT`+2 cycles after accept.
- Unaligned: `doneSending` is high in cycle 2.
- Back-to-back transactions need `tx_flag` low for at least one cycle after `doneSending`.

## Test plan
- Reset then idle: all outputs 0. `tx_flag`=1 with `mode`=100 → no `doneSending`, `busy`=0.
- GPR read, `address_bridged`=5, `rf_rdata`=0x1234_5678 → `rf_addr`=5, `data_internal`=0x12345678, `doneSending` pulse in cycle 3. Holding `tx_flag` high 10 more cycles yields a single pulse.
- GPR write to index 7 with 0xCAFEF00D → `rf_we` high exactly one cycle with that data. Index 0 → no `rf_we`, pulse still occurs.
- Memory read at 0x0000_0104, ack after 3 cycles with 0xA5A5_0F0F → `mem_addr`=0x104, `mem_be`=F, `data_internal`=0xA5A50F0F, `error`=0.
- Memory write at 0x0000_0102 → no `mem_req`, `error`=1, `data_internal`=0, pulse in cycle 2. Next valid accept clears `error`.
- `TIMEOUT`=4 with `mem_ack` held 0 → `mem_req` high 4 cycles, `error`=1, pulse in cycle 6. `RST` asserted while `mem_req`=1 → `mem_req` drops the same cycle, state returns to IDLE.

Source files
------------

// File: rtl/debug_access_unit.sv
// Debug access unit: runs one register-file or data-memory access per tx_flag
// request from the debug controller and closes each with a doneSending pulse.
module debug_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tx_flag,
  input  logic [2:0]  mode,
  input  logic [31:0] address_bridged,
  input  logic [31:0] data_bridged,
  output logic [31:0] data_internal,
  output logic        doneSending,
  output logic        busy,
  output logic        error,
  output logic [4:0]  rf_addr,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [2:0] MODE_RF_RD  = 3'b001;
  localparam logic [2:0] MODE_RF_WR  = 3'b010;
  localparam logic [2:0] MODE_MEM_RD = 3'b101;
  localparam logic [2:0] MODE_MEM_WR = 3'b110;
  localparam logic [15:0] TIMEOUT_L  = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_RF_RD, S_RF_CAP, S_RF_WR, S_MEM_REQ, S_ERR, S_DONE, S_WAIT_LOW
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  mode_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [15:0] cnt_reg;
  logic [31:0] data_internal_reg;
  logic        error_reg;
  logic        valid_mode;
  logic        accept;
  logic        timeout_hit;
  logic        mem_req_int;

  assign valid_mode  = (mode == MODE_RF_RD) || (mode == MODE_RF_WR) ||
                       (mode == MODE_MEM_RD) || (mode == MODE_MEM_WR);
  assign accept      = (state_reg == S_IDLE) && tx_flag && valid_mode;
  assign timeout_hit = (cnt_reg + 16'd1) == TIMEOUT_L;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (tx_flag) begin
          case (mode)
            MODE_RF_RD:  state_next = S_RF_RD;
            MODE_RF_WR:  state_next = S_RF_WR;
            MODE_MEM_RD,
            MODE_MEM_WR: state_next = (address_bridged[1:0] == 2'b00) ? S_MEM_REQ : S_ERR;
            default:     state_next = S_IDLE;
          endcase
        end
      end
      S_RF_RD:   state_next = S_RF_CAP;
      S_RF_CAP:  state_next = S_DONE;
      S_RF_WR:   state_next = S_DONE;
      S_MEM_REQ: begin
        if (mem_ack)          state_next = S_DONE;
        else if (timeout_hit) state_next = S_ERR;
      end
      S_ERR:      state_next = S_DONE;
      S_DONE:     state_next = S_WAIT_LOW;
      // Hold here until the request level drops so it cannot retrigger.
      S_WAIT_LOW: if (!tx_flag) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_reg          <= 3'b000;
      addr_reg          <= 32'd0;
      data_reg          <= 32'd0;
      cnt_reg           <= 16'd0;
      data_internal_reg <= 32'd0;
      error_reg         <= 1'b0;
    end else begin
      if (accept) begin
        mode_reg  <= mode;
        addr_reg  <= address_bridged;
        data_reg  <= data_bridged;
        cnt_reg   <= 16'd0;
        error_reg <= 1'b0;
      end
      case (state_reg)
        S_RF_CAP: data_internal_reg <= rf_rdata;
        S_MEM_REQ: begin
          if (mem_ack) begin
            if (mode_reg == MODE_MEM_RD) data_internal_reg <= mem_rdata;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_ERR: begin
          error_reg         <= 1'b1;
          data_internal_reg <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  // Port outputs decode from state and latched request only, never from tx_flag.
  assign mem_req_int   = (state_reg == S_MEM_REQ);
  assign busy          = (state_reg != S_IDLE);
  assign doneSending   = (state_reg == S_DONE);
  assign error         = error_reg;
  assign data_internal = data_internal_reg;
  assign rf_addr       = addr_reg[4:0];
  assign rf_we         = (state_reg == S_RF_WR) && (addr_reg[4:0] != 5'd0);
  assign rf_wdata      = data_reg;
  assign mem_req       = mem_req_int;
  assign mem_we        = mem_req_int && (mode_reg == MODE_MEM_WR);
  assign mem_addr      = {addr_reg[31:2], 2'b00};
  assign mem_wdata     = data_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_be
      assign mem_be[gi] = mem_req_int;
    end
  endgenerate

endmodule

// File: tb/tb_debug_access_unit.sv
// Randomized bench for debug_access_unit: each transaction's timing, port
// activity and results are checked against a simple transaction-level model.
module tb_debug_access_unit;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        tx_flag = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [31:0] address_bridged = 32'd0;
  logic [31:0] data_bridged = 32'd0;
  logic [31:0] data_internal;
  logic        doneSending, busy, error;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_rf [32];
  logic [31:0] rf_store [32];
  logic [31:0] ref_di = 32'd0;
  logic        ref_err = 1'b0;

  debug_access_unit #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .tx_flag(tx_flag), .mode(mode),
    .address_bridged(address_bridged), .data_bridged(data_bridged),
    .data_internal(data_internal), .doneSending(doneSending), .busy(busy),
    .error(error), .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  // Register file with one-cycle synchronous read; preloaded while in reset.
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) rf_store[i] <= ref_rf[i];
      rf_rdata <= 32'd0;
    end else begin
      if (rf_we) rf_store[rf_addr] <= rf_wdata;
      rf_rdata <= rf_store[rf_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // hold < 0 drops tx_flag right after accept; otherwise it stays high
  // hold cycles past the done pulse. ack_k = 0 means memory never acks.
  task automatic run_txn(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d,
                         input int ack_k, input logic [31:0] rd, input int hold);
    logic        valid, is_mem, aligned, is_ack;
    int          exp_done, exp_req, exp_we;
    int          done_c, pulses, wec, reqc;
    logic [4:0]  idx;
    idx     = a[4:0];
    valid   = (m == 3'b001) || (m == 3'b010) || (m == 3'b101) || (m == 3'b110);
    is_mem  = (m == 3'b101) || (m == 3'b110);
    aligned = (a[1:0] == 2'b00);
    is_ack  = is_mem && aligned && (ack_k > 0);
    exp_req = 0;
    exp_we  = 0;
    if (!valid)               exp_done = 0;
    else if (m == 3'b001)     exp_done = 3;
    else if (m == 3'b010)     exp_done = 2;
    else if (!aligned)        exp_done = 2;
    else if (ack_k > 0)       exp_done = ack_k + 1;
    else                      exp_done = TO + 2;
    if (is_mem && aligned) exp_req = (ack_k > 0) ? ack_k : TO;
    if (m == 3'b010 && idx != 5'd0) exp_we = 1;

    done_c = 0; pulses = 0; wec = 0; reqc = 0;
    @(negedge CLK);
    mode = m; address_bridged = a; data_bridged = d;
    mem_rdata = rd; mem_ack = 1'b0; tx_flag = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge CLK);
      if (c == 1) chk("busy_c1", 32'(busy), 32'(valid));
      if (c == 1 && m == 3'b001) chk("rf_addr_rd", 32'(rf_addr), 32'(idx));
      if (doneSending) begin
        pulses++;
        if (done_c == 0) done_c = c;
      end
      if (rf_we) begin
        wec++;
        chk("rf_we_addr", 32'(rf_addr), 32'(idx));
        chk("rf_wdata", rf_wdata, d);
      end
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin
          chk("mem_addr", mem_addr, {a[31:2], 2'b00});
          chk("mem_be", 32'(mem_be), 32'hF);
          chk("mem_we", 32'(mem_we), 32'(m == 3'b110));
          if (m == 3'b110) chk("mem_wdata", mem_wdata, d);
        end
      end
      mem_ack = is_mem && (ack_k == c);
      if (hold < 0 && c == 1) tx_flag = 1'b0;
      if (!valid && c == 3) tx_flag = 1'b0;
      if (done_c != 0 && c >= done_c + hold) tx_flag = 1'b0;
    end
    mem_ack = 1'b0;

    if (valid) begin
      ref_err = 1'b0;
      if (m == 3'b001) ref_di = ref_rf[idx];
      else if (m == 3'b010 && idx != 5'd0) ref_rf[idx] = d;
      else if (is_mem && !is_ack) begin ref_di = 32'd0; ref_err = 1'b1; end
      else if (m == 3'b101) ref_di = rd;
    end

    chk("done_cycle", 32'(done_c), 32'(exp_done));
    chk("done_pulses", 32'(pulses), valid ? 32'd1 : 32'd0);
    chk("rf_we_cycles", 32'(wec), 32'(exp_we));
    chk("mem_req_cycles", 32'(reqc), 32'(exp_req));
    chk("data_internal", data_internal, ref_di);
    chk("error", 32'(error), 32'(ref_err));
    chk("busy_end", 32'(busy), 32'd0);
    $display("txn mode=%03b addr=0x%08h data=0x%08h ack=%0d hold=%0d done@%0d di=0x%08h err=%0b",
             m, a, d, ack_k, hold, done_c, data_internal, error);
  endtask

  initial begin
    logic [2:0]  codes [8];
    logic [2:0]  m;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) codes[i] = 3'(i);
    ref_rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) ref_rf[i] = $urandom;
    ref_rf[5] = 32'h1234_5678;

    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_outputs", {data_internal ^ rf_wdata ^ mem_addr ^ mem_wdata},  32'd0);
    chk("idle_flags", {24'd0, doneSending, busy, error, rf_we, mem_req, mem_we, 2'b00} | 32'(mem_be) | 32'(rf_addr), 32'd0);

    run_txn(3'b100, 32'h0000_0005, 32'd0, 0, 32'd0, 0);
    run_txn(3'b001, 32'h0000_0005, 32'd0, 0, 32'd0, 10);
    run_txn(3'b010, 32'h0000_0007, 32'hCAFE_F00D, 0, 32'd0, 1);
    run_txn(3'b010, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'd0, 0);
    run_txn(3'b001, 32'h0000_0007, 32'd0, 0, 32'd0, 0);
    run_txn(3'b101, 32'h0000_0104, 32'd0, 3, 32'hA5A5_0F0F, 0);
    run_txn(3'b110, 32'h0000_0102, 32'h1111_2222, 0, 32'd0, 0);
    run_txn(3'b110, 32'h0000_0200, 32'h3333_4444, 1, 32'h5555_6666, 2);
    run_txn(3'b101, 32'h0000_0300, 32'd0, 0, 32'h7777_8888, 0);
    run_txn(3'b001, 32'h0000_0003, 32'd0, 0, 32'd0, -1);

    for (int n = 0; n < 50; n++) begin
      m = codes[$urandom_range(0, 7)];
      a = $urandom;
      if ((m == 3'b101 || m == 3'b110) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (m == 3'b010 && $urandom_range(0, 4) == 0) a[4:0] = 5'd0;
      run_txn(m, a, $urandom, $urandom_range(0, TO), $urandom, $urandom_range(0, 4) - 1);
    end

    // Reset while a memory request is outstanding.
    @(negedge CLK);
    mode = 3'b101; address_bridged = 32'h0000_0040; tx_flag = 1'b1; mem_ack = 1'b0;
    repeat (2) @(negedge CLK);
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    RST = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    tx_flag = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(doneSending), 32'd0);
    chk("post_rst_di", data_internal, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
